ql_bus_ack: RTL
===============

QL_BUS_ACK -- requirements
Module: ql_bus_ack

Interface
REQ-001 Parameter TIMEOUT, default 64: bus-error timeout, counted in ce_bus_p pulses from cycle start; legal range 4..127.
REQ-002 clk_sys  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 ce_bus_p  in  1  single-clk_sys-cycle bus phase strobe; state advances only on it unless stated otherwise.
REQ-005 timing_enable  in  1  high = honour ram_delay_dtack; low = RAM/ROM cycles acknowledge without contention delay.
REQ-006 cpu_as  in  1  CPU address strobe, active high.
REQ-007 cpu_rw  in  1  1 = read, 0 = write.
REQ-008 sel_ram, sel_rom, sel_io  in  1 each  address-decoder region selects, valid while cpu_as is high.
REQ-009 ram_delay_dtack  in  1  RAM contention hold-off from the timing stage; high = do not acknowledge.
REQ-010 io_ready  in  1  peripheral ready; high = I/O cycle may complete.
REQ-011 sdram_oe  out  1  SDRAM read request.
REQ-012 sdram_wr  out  1  SDRAM write request.
REQ-013 cpu_dtack_n  out  1  data acknowledge to CPU, active low.
REQ-014 cpu_berr_n  out  1  bus error to CPU, active low.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 States: IDLE, REQ, WAIT_RAM, WAIT_IO, ACK, BERR, RELEASE.
REQ-017 Region priority when several selects are high: sel_ram > sel_rom > sel_io.
REQ-018 IDLE, on ce_bus_p with cpu_as=1: sel_ram or sel_rom -> REQ; sel_io only -> WAIT_IO; no select -> WAIT_IO (it can only end by timeout).
REQ-019 Entering REQ: sdram_oe=1 if cpu_rw=1; sdram_wr=1 if cpu_rw=0 and sel_ram; ROM write asserts neither strobe but still completes.
REQ-020 REQ -> WAIT_RAM on the next ce_bus_p, unconditionally; this guarantees at least one WAIT_RAM sample.
REQ-021 WAIT_RAM, on ce_bus_p: ram_delay_dtack=0 or timing_enable=0 -> ACK; otherwise stay.
REQ-022 WAIT_IO, on ce_bus_p: io_ready=1 and a select was high at cycle start -> ACK; otherwise stay.
REQ-023 Timeout counter: 7 bits, cleared on leaving IDLE, incremented on each ce_bus_p in REQ/WAIT_RAM/WAIT_IO, saturating at 127.
REQ-024 When the counter equals TIMEOUT in REQ/WAIT_RAM/WAIT_IO -> BERR on that ce_bus_p; the timeout check takes priority over a simultaneous ready condition.
REQ-025 ACK: cpu_dtack_n=0, strobes held; leave to RELEASE in the first clk_sys cycle after cpu_as=0, without waiting for ce_bus_p.
REQ-026 BERR: cpu_berr_n=0, sdram_oe and sdram_wr=0; leave to RELEASE in the first clk_sys cycle after cpu_as=0.
REQ-027 cpu_as=0 in REQ/WAIT_RAM/WAIT_IO (aborted cycle) -> RELEASE on the next clk_sys edge, with no DTACK or BERR pulse.
REQ-028 RELEASE: cpu_dtack_n=1, cpu_berr_n=1, sdram_oe=0, sdram_wr=0; -> IDLE on the next ce_bus_p.
REQ-029 A new cycle is never started from RELEASE, even if cpu_as is already high again; it starts from IDLE on a later ce_bus_p.
REQ-030 All outputs are registered; cpu_dtack_n and cpu_berr_n are never low simultaneously.

Reset
REQ-031 reset=1 forces state IDLE, counter 0, sdram_oe=0, sdram_wr=0, cpu_dtack_n=1, cpu_berr_n=1, busy=0 on the next clk_sys edge.
REQ-032 reset mid-cycle: the same values apply on the next edge; no DTACK is issued for the interrupted cycle after reset is released.

Verification
REQ-033 RAM read, timing_enable=1, ram_delay_dtack high for 3 ce_bus_p after REQ -> sdram_oe=1 from REQ; cpu_dtack_n=0 on the first ce_bus_p with ram_delay_dtack=0.
REQ-034 RAM write, timing_enable=0 -> sdram_wr=1 from REQ; cpu_dtack_n=0 two ce_bus_p after cycle start; cpu_as drop -> dtack_n=1 and sdram_wr=0 one clk later.
REQ-035 ROM write -> sdram_oe=0 and sdram_wr=0 throughout; DTACK is still issued.
REQ-036 Unmapped access, TIMEOUT=4 -> cpu_berr_n=0 on the 4th ce_bus_p after cycle start; cpu_dtack_n stays 1.
REQ-037 sel_ram and sel_io both high, io_ready=0 -> RAM path taken; ACK is independent of io_ready.
REQ-038 cpu_as dropped in WAIT_RAM, then reset pulsed in ACK of a following cycle -> no DTACK for the abort; all outputs return to reset values one clk after reset.

Source files
------------

// File: rtl/ql_bus_ack.sv
// CPU bus acknowledge sequencer: turns address-strobe cycles into SDRAM requests
// and DTACK/BERR responses, stepping on the bus-phase strobe ce_bus_p.
module ql_bus_ack #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ce_bus_p,
  input  logic timing_enable,
  input  logic cpu_as,
  input  logic cpu_rw,
  input  logic sel_ram,
  input  logic sel_rom,
  input  logic sel_io,
  input  logic ram_delay_dtack,
  input  logic io_ready,
  output logic sdram_oe,
  output logic sdram_wr,
  output logic cpu_dtack_n,
  output logic cpu_berr_n,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RAM,
    WAIT_IO,
    ACK,
    BERR,
    RELEASE
  } state_e;

  localparam logic [6:0] TimeoutVal = TIMEOUT[6:0];

  state_e     stateQ, stateD;
  logic [6:0] countQ, countD;
  logic       selQ, selD;
  logic       oeQ, oeD;
  logic       wrQ, wrD;
  logic       dtackNQ, dtackND;
  logic       berrNQ, berrND;
  logic       busyQ, busyD;
  logic [6:0] countInc;
  logic       timeoutHit;

  // The comparison uses the value the counter takes on this strobe, so the
  // bus error lands on the TIMEOUT-th strobe after the one that started the cycle.
  assign countInc   = (countQ == 7'd127) ? countQ : countQ + 7'd1;
  assign timeoutHit = (countInc == TimeoutVal);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stateQ  <= IDLE;
      countQ  <= 7'd0;
      selQ    <= 1'b0;
      oeQ     <= 1'b0;
      wrQ     <= 1'b0;
      dtackNQ <= 1'b1;
      berrNQ  <= 1'b1;
      busyQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      countQ  <= countD;
      selQ    <= selD;
      oeQ     <= oeD;
      wrQ     <= wrD;
      dtackNQ <= dtackND;
      berrNQ  <= berrND;
      busyQ   <= busyD;
    end
  end

  always_comb begin
    stateD = stateQ;
    countD = countQ;
    selD   = selQ;
    oeD    = oeQ;
    wrD    = wrQ;

    unique case (stateQ)
      IDLE: begin
        if (ce_bus_p && cpu_as) begin
          countD = 7'd0;
          selD   = sel_ram | sel_rom | sel_io;
          if (sel_ram || sel_rom) begin
            stateD = REQ;
            oeD    = cpu_rw;
            wrD    = !cpu_rw && sel_ram;
          end else begin
            stateD = WAIT_IO;
            oeD    = 1'b0;
            wrD    = 1'b0;
          end
        end
      end
      REQ, WAIT_RAM, WAIT_IO: begin
        // An abort needs no strobe and beats a same-cycle timeout or ready.
        if (!cpu_as) begin
          stateD = RELEASE;
        end else if (ce_bus_p) begin
          countD = countInc;
          if (timeoutHit) begin
            stateD = BERR;
          end else if (stateQ == REQ) begin
            stateD = WAIT_RAM;
          end else if (stateQ == WAIT_RAM && (!ram_delay_dtack || !timing_enable)) begin
            stateD = ACK;
          end else if (stateQ == WAIT_IO && io_ready && selQ) begin
            stateD = ACK;
          end
        end
      end
      ACK, BERR: begin
        if (!cpu_as) begin
          stateD = RELEASE;
        end
      end
      RELEASE: begin
        if (ce_bus_p) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase

    if (stateD inside {BERR, RELEASE, IDLE}) begin
      oeD = 1'b0;
      wrD = 1'b0;
    end

    dtackND = (stateD != ACK);
    berrND  = (stateD != BERR);
    busyD   = (stateD != IDLE);
  end

  assign sdram_oe    = oeQ;
  assign sdram_wr    = wrQ;
  assign cpu_dtack_n = dtackNQ;
  assign cpu_berr_n  = berrNQ;
  assign busy        = busyQ;

endmodule
